// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register plus register-file write port, with load alignment/extension.
// Latency: In* captured at edge N drives RegWrite/WriteRegister/WriteData during cycle N; ReadDataN is combinational.
// Backpressure: Stall holds the stage (a held write re-issues and is counted each cycle); Flush inserts a bubble.
// Optional macro WB_BYPASS_EN: forward the in-flight write onto ReadData1/2 (default: ReadDataN = RfDataN).
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic              InRegWrite,
  input  logic              InMemtoReg,
  input  logic [1:0]        InLoadSize,
  input  logic              InLoadSigned,
  input  logic [1:0]        InAddrLow,
  input  logic [4:0]        InWriteRegister,
  input  logic [DATA_W-1:0] InALUResult,
  input  logic [DATA_W-1:0] InMemData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  input  logic [DATA_W-1:0] RfData1,
  input  logic [DATA_W-1:0] RfData2,
  output logic              RegWrite,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              WbValid,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [CNT_W-1:0]  WbCount
);

  logic              wbRegWrite;
  logic              wbMemtoReg;
  logic [1:0]        wbLoadSize;
  logic              wbLoadSigned;
  logic [1:0]        wbAddrLow;
  logic [DATA_W-1:0] wbALUResult;
  logic [DATA_W-1:0] wbMemData;
  logic [15:0]       halfSel;
  logic [7:0]        byteSel;

  // Stage register: reset clears everything, Flush only drops valid, Stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      WbValid       <= 1'b0;
      wbRegWrite    <= 1'b0;
      wbMemtoReg    <= 1'b0;
      wbLoadSize    <= 2'b00;
      wbLoadSigned  <= 1'b0;
      wbAddrLow     <= 2'b00;
      WriteRegister <= 5'd0;
      wbALUResult   <= '0;
      wbMemData     <= '0;
    end else if (Flush) begin
      WbValid <= 1'b0;
    end else if (!Stall) begin
      WbValid       <= InValid;
      wbRegWrite    <= InRegWrite;
      wbMemtoReg    <= InMemtoReg;
      wbLoadSize    <= InLoadSize;
      wbLoadSigned  <= InLoadSigned;
      wbAddrLow     <= InAddrLow;
      WriteRegister <= InWriteRegister;
      wbALUResult   <= InALUResult;
      wbMemData     <= InMemData;
    end
  end

  // $0 is hardwired, so writes to it are suppressed here rather than in the register file.
  assign RegWrite = WbValid & wbRegWrite & (WriteRegister != 5'd0);

  // Big-endian lane select and extension of load data; ALU result when not a load.
  always_comb begin
    halfSel   = wbAddrLow[1] ? wbMemData[15:0] : wbMemData[31:16];
    byteSel   = wbMemData[31:24];
    WriteData = wbMemData;
    case (wbAddrLow)
      2'd0:    byteSel = wbMemData[31:24];
      2'd1:    byteSel = wbMemData[23:16];
      2'd2:    byteSel = wbMemData[15:8];
      default: byteSel = wbMemData[7:0];
    endcase
    if (!wbMemtoReg) begin
      WriteData = wbALUResult;
    end else begin
      case (wbLoadSize)
        2'b01:   WriteData = {{(DATA_W-16){wbLoadSigned & halfSel[15]}}, halfSel};
        2'b10:   WriteData = {{(DATA_W-8){wbLoadSigned & byteSel[7]}}, byteSel};
        default: WriteData = wbMemData;
      endcase
    end
  end

  // Committed-write counter; a stalled write counts once per cycle it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      WbCount <= '0;
    end else if (RegWrite) begin
      WbCount <= WbCount + CNT_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write being committed this cycle, since the register file returns the old value.
  always_comb begin
    ReadData1 = RfData1;
    ReadData2 = RfData2;
    if (ReadRegister1 == 5'd0) begin
      ReadData1 = '0;
    end else if (RegWrite && (WriteRegister == ReadRegister1)) begin
      ReadData1 = WriteData;
    end
    if (ReadRegister2 == 5'd0) begin
      ReadData2 = '0;
    end else if (RegWrite && (WriteRegister == ReadRegister2)) begin
      ReadData2 = WriteData;
    end
  end
`else
  logic unusedReadRegs;
  assign ReadData1      = RfData1;
  assign ReadData2      = RfData2;
  assign unusedReadRegs = ^{ReadRegister1, ReadRegister2};
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vectors, an instruction-level model, and per-cycle comparison.
module tb_mem_wb_writeback;

  localparam int NLOADS = 11;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, InValid, InRegWrite, InMemtoReg, InLoadSigned;
  logic [1:0]  InLoadSize, InAddrLow;
  logic [4:0]  InWriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] InALUResult, InMemData, RfData1, RfData2;
  logic        RegWrite, WbValid;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, ReadData1, ReadData2, WbCount;

  int errors = 0;
  int checks = 0;

  // Model of the instruction currently in the stage
  logic        started = 1'b0;
  logic        mValid, mWe, mKnown;
  logic [4:0]  mRd;
  logic [31:0] mData;
  logic [31:0] mCount;

  // Load table
  logic [1:0]  tSize [NLOADS];
  logic        tSgn  [NLOADS];
  logic [1:0]  tOff  [NLOADS];
  logic [31:0] tExp  [NLOADS];

  mem_wb_writeback #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .InRegWrite(InRegWrite), .InMemtoReg(InMemtoReg), .InLoadSize(InLoadSize),
    .InLoadSigned(InLoadSigned), .InAddrLow(InAddrLow), .InWriteRegister(InWriteRegister),
    .InALUResult(InALUResult), .InMemData(InMemData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RfData1(RfData1), .RfData2(RfData2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WbValid(WbValid), .ReadData1(ReadData1), .ReadData2(ReadData2), .WbCount(WbCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value written for an instruction, computed by byte arithmetic on the memory word.
  function automatic logic [31:0] wbValue(input logic memtoReg, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] off,
                                          input logic [31:0] alu, input logic [31:0] mem);
    longint nBytes, firstByte, val, span;
    if (!memtoReg) return alu;
    if (size == 2'b01) begin
      nBytes = 2; firstByte = longint'(off & 2'b10);
    end else if (size == 2'b10) begin
      nBytes = 1; firstByte = longint'(off);
    end else begin
      return mem;
    end
    span = longint'(1) << (8 * nBytes);
    val  = (longint'(mem) >> (8 * (4 - firstByte - nBytes))) % span;
    if (sgn && val >= span / 2) val = val - span + (longint'(1) << 32);
    return val[31:0];
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] rr, input logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (rr == 5'd0) return 32'd0;
    if (mWe && mRd == rr) return mData;
`endif
    return rf;
  endfunction

  // Model update at each edge; the count uses the write presented before the edge.
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      mValid = 1'b0; mWe = 1'b0; mKnown = 1'b1; mRd = 5'd0; mData = 32'd0; mCount = 32'd0;
    end else begin
      if (mWe) mCount = mCount + 32'd1;
      if (Flush) begin
        mValid = 1'b0; mWe = 1'b0; mKnown = 1'b0;
      end else if (!Stall) begin
        mValid = InValid;
        mRd    = InWriteRegister;
        mWe    = InValid && InRegWrite && (InWriteRegister != 5'd0);
        mData  = wbValue(InMemtoReg, InLoadSize, InLoadSigned, InAddrLow, InALUResult, InMemData);
        mKnown = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("RegWrite", 32'(RegWrite), 32'(mWe));
      check("WbValid", 32'(WbValid), 32'(mValid));
      check("WbCount", WbCount, mCount);
      if (mKnown) begin
        check("WriteRegister", 32'(WriteRegister), 32'(mRd));
        check("WriteData", WriteData, mData);
      end
      check("ReadData1", ReadData1, expRead(ReadRegister1, RfData1));
      check("ReadData2", ReadData2, expRead(ReadRegister2, RfData2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic v, input logic we, input logic [4:0] rd,
                          input logic [31:0] alu);
    InValid = v; InRegWrite = we; InWriteRegister = rd; InALUResult = alu;
    InMemtoReg = 1'b0; InLoadSize = 2'b00; InLoadSigned = 1'b0; InAddrLow = 2'b00;
  endtask

  initial begin
    logic [31:0] base;
    tSize[0]  = 2'b10; tSgn[0]  = 1'b1; tOff[0]  = 2'd0; tExp[0]  = 32'hFFFF_FF80;
    tSize[1]  = 2'b10; tSgn[1]  = 1'b0; tOff[1]  = 2'd3; tExp[1]  = 32'h0000_0001;
    tSize[2]  = 2'b01; tSgn[2]  = 1'b1; tOff[2]  = 2'd2; tExp[2]  = 32'h0000_7F01;
    tSize[3]  = 2'b01; tSgn[3]  = 1'b1; tOff[3]  = 2'd0; tExp[3]  = 32'hFFFF_80FF;
    tSize[4]  = 2'b10; tSgn[4]  = 1'b1; tOff[4]  = 2'd1; tExp[4]  = 32'hFFFF_FFFF;
    tSize[5]  = 2'b10; tSgn[5]  = 1'b1; tOff[5]  = 2'd2; tExp[5]  = 32'h0000_007F;
    tSize[6]  = 2'b01; tSgn[6]  = 1'b0; tOff[6]  = 2'd0; tExp[6]  = 32'h0000_80FF;
    tSize[7]  = 2'b01; tSgn[7]  = 1'b1; tOff[7]  = 2'd3; tExp[7]  = 32'h0000_7F01;
    tSize[8]  = 2'b00; tSgn[8]  = 1'b1; tOff[8]  = 2'd1; tExp[8]  = 32'h80FF_7F01;
    tSize[9]  = 2'b11; tSgn[9]  = 1'b1; tOff[9]  = 2'd2; tExp[9]  = 32'h80FF_7F01;
    tSize[10] = 2'b10; tSgn[10] = 1'b0; tOff[10] = 2'd0; tExp[10] = 32'h0000_0080;

    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; RfData1 = 32'd0; RfData2 = 32'd0;
    InMemData = 32'd0;

    // Reset with random instruction inputs
    for (int i = 0; i < 2; i++) begin
      setInstr(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      InMemData = $urandom; InMemtoReg = 1'($urandom); InLoadSize = 2'($urandom);
      cyc(); #2;
      check("rst_RegWrite", 32'(RegWrite), 32'd0);
      check("rst_WriteData", WriteData, 32'd0);
      check("rst_WbValid", 32'(WbValid), 32'd0);
      check("rst_WbCount", WbCount, 32'd0);
    end
    rst = 1'b0;

    // ALU write to $8
    setInstr(1'b1, 1'b1, 5'd8, 32'h1234_5678);
    cyc(); #2;
    check("alu_RegWrite", 32'(RegWrite), 32'd1);
    check("alu_WriteRegister", 32'(WriteRegister), 32'd8);
    check("alu_WriteData", WriteData, 32'h1234_5678);
    check("alu_WbCount_pre", WbCount, 32'd0);
    setInstr(1'b0, 1'b0, 5'd0, 32'd0);
    cyc(); #2;
    check("alu_WbCount_post", WbCount, 32'd1);

    // Loads from 0x80FF7F01, back to back into $3
    InMemData = 32'h80FF_7F01;
    for (int i = 0; i < NLOADS; i++) begin
      setInstr(1'b1, 1'b1, 5'd3, 32'hA5A5_0000 + 32'(i));
      InMemtoReg = 1'b1; InLoadSize = tSize[i]; InLoadSigned = tSgn[i]; InAddrLow = tOff[i];
      cyc(); #2;
      check($sformatf("load%0d_WriteData", i), WriteData, tExp[i]);
    end

    // Write to $0 is suppressed and not counted
    setInstr(1'b1, 1'b1, 5'd0, 32'hCAFE_0000);
    cyc(); #2;
    check("r0_RegWrite", 32'(RegWrite), 32'd0);
    check("r0_WbCount", WbCount, 32'(1 + NLOADS));
    setInstr(1'b1, 1'b1, 5'd7, 32'h7777_7777);
    Stall = 1'b1; Flush = 1'b1;
    cyc(); #2;
    check("flush_WbValid", 32'(WbValid), 32'd0);
    check("flush_RegWrite", 32'(RegWrite), 32'd0);
    check("flush_WbCount", WbCount, 32'(1 + NLOADS));
    Stall = 1'b0; Flush = 1'b0;

    // Stall a write to $5 for three cycles
    base = 32'(1 + NLOADS);
    setInstr(1'b1, 1'b1, 5'd5, 32'h0000_0055);
    cyc(); #2;
    check("stall_cap_WriteRegister", 32'(WriteRegister), 32'd5);
    Stall = 1'b1;
    setInstr(1'b1, 1'b1, 5'd6, 32'h0000_0066);
    for (int i = 1; i <= 3; i++) begin
      cyc(); #2;
      check("stall_hold_WriteRegister", 32'(WriteRegister), 32'd5);
      check("stall_hold_WriteData", WriteData, 32'h0000_0055);
      check("stall_hold_WbCount", WbCount, base + 32'(i));
    end
    Stall = 1'b0;
    cyc(); #2;
    check("release_WriteRegister", 32'(WriteRegister), 32'd6);
    check("release_WriteData", WriteData, 32'h0000_0066);
    check("release_WbCount", WbCount, base + 32'd4);

    // Decode-stage read of the in-flight write
    setInstr(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    ReadRegister1 = 5'd9; RfData1 = 32'd0; ReadRegister2 = 5'd0; RfData2 = 32'h0000_1111;
    cyc(); #2;
`ifdef WB_BYPASS_EN
    check("byp_ReadData1", ReadData1, 32'hDEAD_BEEF);
    check("byp_ReadData2_r0", ReadData2, 32'd0);
`else
    check("nobyp_ReadData1", ReadData1, 32'd0);
    check("nobyp_ReadData2", ReadData2, 32'h0000_1111);
`endif
    ReadRegister2 = 5'd9; RfData2 = 32'h0000_2222; ReadRegister1 = 5'd10; RfData1 = 32'h0000_3333;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_ReadData2", ReadData2, 32'hDEAD_BEEF);
`else
    check("nobyp_ReadData2_r9", ReadData2, 32'h0000_2222);
`endif
    check("nomatch_ReadData1", ReadData1, 32'h0000_3333);

    setInstr(1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) cyc();
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
